burst_ram_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the PSRAM burst interface (br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask, br_rd_data, br_rd_data_valid).
- Shares the PSRAM between requester 0 (RAMIO cache) and requester 1 (flash loader / DMA).
- Sits between the requesters and PSRAM_Memory_Interface_HS_V2_Top in the br_clk_out domain.
- Issues one burst command at a time, holds the grant until the burst completes, then enforces an inter-command gap.

---
 rtl/burst_ram_arbiter_if.sv | 32 +++
 rtl/burst_ram_arbiter.sv | 148 ++++++++++++++
 tb/tb_burst_ram_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/burst_ram_arbiter_if.sv
// burst_ram_arbiter_if: requester-side and PSRAM burst-side signal bundle.
// master is the arbiter's view; slave is the view of whatever drives the requests and the PSRAM.
interface burst_ram_arbiter_if #(parameter int ADDR_W = 21);
  logic                  init_calib;
  logic [1:0]            req_valid;
  logic [1:0]            req_write;
  logic [2*ADDR_W-1:0]   req_addr;
  logic [127:0]          req_wr_data;
  logic [1:0]            req_ready;
  logic [1:0]            req_wr_next;
  logic [63:0]           req_rd_data;
  logic [1:0]            req_rd_valid;
  logic [1:0]            req_done;
  logic [1:0]            req_error;
  logic                  br_cmd;
  logic                  br_cmd_en;
  logic [ADDR_W-1:0]     br_addr;
  logic [63:0]           br_wr_data;
  logic [7:0]            br_data_mask;
  logic [63:0]           br_rd_data;
  logic                  br_rd_data_valid;
  modport master (
    input  init_calib, req_valid, req_write, req_addr, req_wr_data, br_rd_data, br_rd_data_valid,
    output req_ready, req_wr_next, req_rd_data, req_rd_valid, req_done, req_error,
           br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask
  );
  modport slave (
    output init_calib, req_valid, req_write, req_addr, req_wr_data, br_rd_data, br_rd_data_valid,
    input  req_ready, req_wr_next, req_rd_data, req_rd_valid, req_done, req_error,
           br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask
  );
endinterface

// File: rtl/burst_ram_arbiter.sv
// burst_ram_arbiter: round-robin two-requester PSRAM burst sequencer with post-burst command gap.
// Define BR_ARB_TIMEOUT_EN to add a read watchdog that aborts stalled bursts via req_error.
module burst_ram_arbiter #(
  parameter int ADDR_W         = 21,
  parameter int BURST_BEATS    = 4,
  parameter int CMD_GAP_CYCLES = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic clk,
  input logic rst,
  burst_ram_arbiter_if.master bus
);
  localparam int BW = $clog2(BURST_BEATS + 1);
  localparam int GW = CMD_GAP_CYCLES > 0 ? $clog2(CMD_GAP_CYCLES + 1) : 1;
  typedef enum logic [2:0] {IDLE, CMD, WRITE, READ, GAP} state_t;
  // A zero gap skips GAP entirely so the next grant can happen the cycle after done
  localparam state_t AFTER = state_t'(CMD_GAP_CYCLES > 0 ? GAP : IDLE);
  state_t state_q, state_d;
  logic last_q, last_d, grant_q, grant_d, wr_q, wr_d, win;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [1:0] sel;
  logic [63:0] beat_data;
`ifdef BR_ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd_q, wd_d;
`endif
  assign sel = bus.req_valid & {2{bus.init_calib}};
  assign win = sel == 2'b10 ? 1'b1 : sel == 2'b01 ? 1'b0 : ~last_q;
  assign beat_data = grant_q ? bus.req_wr_data[127:64] : bus.req_wr_data[63:0];
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    grant_d = grant_q;
    wr_d = wr_q;
    addr_d = addr_q;
    beat_d = beat_q;
    gap_d = gap_q;
`ifdef BR_ARB_TIMEOUT_EN
    wd_d = wd_q;
`endif
    bus.req_ready = '0;
    bus.req_wr_next = '0;
    bus.req_rd_valid = '0;
    bus.req_done = '0;
    bus.req_error = '0;
    bus.req_rd_data = bus.br_rd_data;
    bus.br_cmd = 1'b0;
    bus.br_cmd_en = 1'b0;
    bus.br_addr = '0;
    bus.br_wr_data = '0;
    bus.br_data_mask = '0;
    case (state_q)
      IDLE: if (|sel) begin
        bus.req_ready[win] = 1'b1;
        grant_d = win;
        last_d = win;
        wr_d = bus.req_write[win];
        addr_d = win ? bus.req_addr[2*ADDR_W-1:ADDR_W] : bus.req_addr[ADDR_W-1:0];
        state_d = CMD;
      end
      CMD: begin
        bus.br_cmd_en = 1'b1;
        bus.br_cmd = wr_q;
        bus.br_addr = addr_q;
        beat_d = '0;
`ifdef BR_ARB_TIMEOUT_EN
        wd_d = '0;
`endif
        if (wr_q) begin
          bus.br_wr_data = beat_data;
          bus.req_wr_next[grant_q] = 1'b1;
          if (BURST_BEATS == 1) begin
            bus.req_done[grant_q] = 1'b1;
            state_d = AFTER;
          end else begin
            beat_d = BW'(1);
            state_d = WRITE;
          end
        end else state_d = READ;
      end
      WRITE: begin
        bus.br_wr_data = beat_data;
        bus.req_wr_next[grant_q] = 1'b1;
        beat_d = beat_q + BW'(1);
        if (beat_q == BW'(BURST_BEATS - 1)) begin
          bus.req_done[grant_q] = 1'b1;
          beat_d = '0;
          state_d = AFTER;
        end
      end
      READ: begin
        if (bus.br_rd_data_valid) begin
          bus.req_rd_valid[grant_q] = 1'b1;
          beat_d = beat_q + BW'(1);
          if (beat_q == BW'(BURST_BEATS - 1)) begin
            bus.req_done[grant_q] = 1'b1;
            beat_d = '0;
            state_d = AFTER;
          end
        end
`ifdef BR_ARB_TIMEOUT_EN
        // A final beat landing on the timeout cycle still completes normally
        wd_d = wd_q + WW'(1);
        if (state_d == READ && wd_q == WW'(TIMEOUT_CYCLES)) begin
          bus.req_error[grant_q] = 1'b1;
          beat_d = '0;
          state_d = AFTER;
        end
`endif
      end
      GAP: begin
        gap_d = gap_q + GW'(1);
        if (gap_q == GW'(CMD_GAP_CYCLES - 1)) begin
          gap_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      grant_q <= 1'b0;
      wr_q <= 1'b0;
      addr_q <= '0;
      beat_q <= '0;
      gap_q <= '0;
`ifdef BR_ARB_TIMEOUT_EN
      wd_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      grant_q <= grant_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      beat_q <= beat_d;
      gap_q <= gap_d;
`ifdef BR_ARB_TIMEOUT_EN
      wd_q <= wd_d;
`endif
    end
  end
endmodule

// File: tb/tb_burst_ram_arbiter.sv
// tb_burst_ram_arbiter: directed checks of grant, burst sequencing, gap, calibration gating,
// mid-burst reset and (with BR_ARB_TIMEOUT_EN) the read watchdog.
module tb_burst_ram_arbiter;
  logic clk, rst;
  int tests, fails, n, bad, cmd_cnt, done_seen;
  logic [63:0] a_beats [4];
  logic [63:0] d_beats [4];
  burst_ram_arbiter_if #(.ADDR_W(21)) b();
  burst_ram_arbiter #(.TIMEOUT_CYCLES(16)) dut (.clk(clk), .rst(rst), .bus(b.master));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  initial begin
    tests = 0; fails = 0;
    a_beats = '{64'hA0A0_0000_0000_00A0, 64'hA1A1_1111_1111_11A1, 64'hA2A2_2222_2222_22A2, 64'hA3A3_3333_3333_33A3};
    d_beats = '{64'hD000_0000_0000_0D00, 64'hD111_1111_1111_1D11, 64'hD222_2222_2222_2D22, 64'hD333_3333_3333_3D33};
    rst = 1'b1;
    b.init_calib = 1'b1;
    b.req_valid = '0; b.req_write = '0; b.req_addr = '0; b.req_wr_data = '0;
    b.br_rd_data = 64'h1234_5678_9ABC_DEF0; b.br_rd_data_valid = 1'b1;
    tick; tick; #1;
    chk("rst_ready", b.req_ready, 2'b00);
    chk("rst_cmd_en", b.br_cmd_en, 1'b0);
    chk("rst_rd_valid", b.req_rd_valid, 2'b00);
    chk("rst_wr_data", b.br_wr_data, 64'h0);
    chk("rst_addr", b.br_addr, 21'h0);
    chk("rst_mask", b.br_data_mask, 8'h0);
    chk("rst_rd_mirror", b.req_rd_data, 64'h1234_5678_9ABC_DEF0);
    // write burst from requester 0
    rst = 1'b0; b.br_rd_data_valid = 1'b0;
    b.req_valid = 2'b01; b.req_write = 2'b01; b.req_addr[20:0] = 21'h00100; b.req_wr_data[63:0] = a_beats[0];
    #1;
    chk("wr_ready", b.req_ready, 2'b01);
    chk("wr_no_cmd_at_T", b.br_cmd_en, 1'b0);
    tick; b.req_valid = 2'b00; #1;
    chk("wr_cmd_en", b.br_cmd_en, 1'b1);
    chk("wr_cmd", b.br_cmd, 1'b1);
    chk("wr_addr", b.br_addr, 21'h00100);
    chk("wr_beat0", b.br_wr_data, a_beats[0]);
    chk("wr_next0", b.req_wr_next, 2'b01);
    for (int k = 1; k < 4; k++) begin
      tick; b.req_wr_data[63:0] = a_beats[k]; #1;
      chk("wr_beat", b.br_wr_data, a_beats[k]);
      chk("wr_next", b.req_wr_next, 2'b01);
      chk("wr_done", b.req_done, k == 3 ? 2'b01 : 2'b00);
      chk("wr_cmd_en_off", b.br_cmd_en, 1'b0);
    end
    // requester 1 read queued right after done; gap holds it off until T+7
    tick; b.req_valid = 2'b10; b.req_write = 2'b00; b.req_addr[41:21] = 21'h1FFFF; #1;
    chk("gap1_ready", b.req_ready, 2'b00);
    chk("gap1_wr_data", b.br_wr_data, 64'h0);
    tick; #1;
    chk("gap2_ready", b.req_ready, 2'b00);
    chk("gap2_cmd_en", b.br_cmd_en, 1'b0);
    tick; #1;
    chk("rd_ready", b.req_ready, 2'b10);
    tick; b.req_valid = 2'b00; #1;
    chk("rd_cmd_en", b.br_cmd_en, 1'b1);
    chk("rd_cmd", b.br_cmd, 1'b0);
    chk("rd_addr", b.br_addr, 21'h1FFFF);
    chk("rd_wr_next", b.req_wr_next, 2'b00);
    for (int k = 0; k < 4; k++) begin
      tick; b.br_rd_data_valid = 1'b0; #1;
      chk("rd_idle", b.req_rd_valid, 2'b00);
      tick; b.br_rd_data_valid = 1'b1; b.br_rd_data = d_beats[k]; #1;
      chk("rd_valid", b.req_rd_valid, 2'b10);
      chk("rd_data", b.req_rd_data, d_beats[k]);
      chk("rd_done", b.req_done, k == 3 ? 2'b10 : 2'b00);
    end
    tick; b.br_rd_data = 64'hBAD0_BAD0_BAD0_BAD0; #1;
    chk("stray_rd_valid", b.req_rd_valid, 2'b00);
    chk("stray_done", b.req_done, 2'b00);
    tick; b.br_rd_data_valid = 1'b0;
    // round robin with both requesters continuously valid
    b.req_valid = 2'b11; b.req_write = 2'b11; #1;
    for (int t = 0; t < 4; t++) begin
      n = 0; cmd_cnt = 0; done_seen = 0;
      while (b.req_ready == 2'b00 && n < 20) begin
        tick; #1; n++;
        cmd_cnt += int'(b.br_cmd_en);
        if (b.req_done != 2'b00) done_seen = 1;
      end
      chk("rr_grant", b.req_ready, t % 2 == 1 ? 2'b10 : 2'b01);
      if (t > 0) begin
        chk("rr_spacing", n, 6);
        chk("rr_no_extra_cmd", cmd_cnt, 0);
        chk("rr_done_between", done_seen, 1);
      end
      tick; #1;
      chk("rr_cmd_en", b.br_cmd_en, 1'b1);
    end
    b.req_valid = 2'b00;
    repeat (10) tick;
    // calibration gating
    b.init_calib = 1'b0; b.req_valid = 2'b11; b.req_write = 2'b00; b.req_addr[20:0] = 21'h00200;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (b.req_ready != 2'b00 || b.br_cmd_en) bad++;
      tick;
    end
    chk("calib_blocked", bad, 0);
    b.init_calib = 1'b1; #1;
    chk("calib_ready", b.req_ready, 2'b01);
    // read from requester 0, reset after beat 2
    tick; b.req_valid = 2'b00; #1;
    chk("rst_rd_cmd_en", b.br_cmd_en, 1'b1);
    tick; b.br_rd_data_valid = 1'b1; b.br_rd_data = d_beats[0]; #1;
    chk("rst_rd_beat1", b.req_rd_valid, 2'b01);
    tick; b.br_rd_data = d_beats[1]; #1;
    chk("rst_rd_beat2", b.req_rd_valid, 2'b01);
    chk("rst_rd_beat2_done", b.req_done, 2'b00);
    tick; b.br_rd_data_valid = 1'b0; rst = 1'b1;
    tick; rst = 1'b0; b.br_rd_data_valid = 1'b1; b.br_rd_data = d_beats[2]; #1;
    chk("late_beat3_valid", b.req_rd_valid, 2'b00);
    chk("late_beat3_done", b.req_done, 2'b00);
    tick; b.br_rd_data = d_beats[3]; #1;
    chk("late_beat4_valid", b.req_rd_valid, 2'b00);
    chk("late_beat4_done", b.req_done, 2'b00);
    tick; b.br_rd_data_valid = 1'b0;
    b.req_valid = 2'b10; b.req_write = 2'b00; b.req_addr[41:21] = 21'h00ABC; #1;
    chk("post_rst_ready", b.req_ready, 2'b10);
    tick; b.req_valid = 2'b00; #1;
    chk("post_rst_cmd_en", b.br_cmd_en, 1'b1);
    chk("post_rst_addr", b.br_addr, 21'h00ABC);
    tick; b.br_rd_data_valid = 1'b1; b.br_rd_data = d_beats[0]; #1;
    chk("post_rst_beat", b.req_rd_valid, 2'b10);
`ifdef BR_ARB_TIMEOUT_EN
    bad = 0;
    for (int i = 1; i < 16; i++) begin
      tick; b.br_rd_data_valid = 1'b0; #1;
      if (b.req_error != 2'b00 || b.req_done != 2'b00) bad++;
    end
    chk("wd_quiet", bad, 0);
    tick; #1;
    chk("wd_error", b.req_error, 2'b10);
    chk("wd_no_done", b.req_done, 2'b00);
    tick; #1;
    chk("wd_error_pulse", b.req_error, 2'b00);
`else
    chk("no_wd_error0", b.req_error, 2'b00);
    for (int k = 1; k < 4; k++) begin
      tick; b.br_rd_data = d_beats[k]; #1;
      chk("post_rst_beat", b.req_rd_valid, 2'b10);
      chk("post_rst_done", b.req_done, k == 3 ? 2'b10 : 2'b00);
      chk("no_wd_error", b.req_error, 2'b00);
    end
    tick; b.br_rd_data_valid = 1'b0;
`endif
    // arbitration resumes
    b.req_valid = 2'b01; b.req_write = 2'b01; #1;
    n = 0;
    while (b.req_ready == 2'b00 && n < 30) begin
      tick; #1; n++;
    end
    chk("resume_ready", b.req_ready, 2'b01);
    tick; b.req_valid = 2'b00; #1;
    chk("resume_cmd_en", b.br_cmd_en, 1'b1);
    chk("resume_cmd", b.br_cmd, 1'b1);
    repeat (8) tick;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
